ascon_av_result_drain: RTL and testbench

- Downstream stage of the ASCON-128a AEAD core.
- Snapshots the core's 384-bit ciphertext+tag bus and 256-bit plaintext bus once the combinationally/sequentially driven outputs have settled after a new ps_in request.
- Flags authentication failure: the core drives all-ones plaintext on tag mismatch.
- Drains the snapshot as a 20-beat 32-bit AXI-Stream-style word sequence toward the PS readout path.

---
 rtl/ascon_pkg.sv | 22 ++
 rtl/ascon_av_result_drain_if.sv | 27 ++
 rtl/ascon_av_result_drain.sv | 133 +++++++++++++
 tb/tb_ascon_av_result_drain.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared types and constants for the ASCON-128a result drain.
package ascon_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StStream,
        StDone
    } state_e;

    localparam int unsigned ASCON_WORD_W = 32;
    localparam int unsigned ASCON_CT_W   = 384;
    localparam int unsigned ASCON_PT_W   = 256;

    localparam int unsigned CT_BEATS    = ASCON_CT_W / ASCON_WORD_W;
    localparam int unsigned PT_BEATS    = ASCON_PT_W / ASCON_WORD_W;
    localparam int unsigned TOTAL_BEATS = CT_BEATS + PT_BEATS;

    // The core drives this plaintext when the tag check fails.
    localparam logic [ASCON_PT_W-1:0] ASCON_FAIL_PT = '1;

endpackage

// File: rtl/ascon_av_result_drain_if.sv
// AXI-Stream-style beat channel from the result drain to the PS readout path.
interface ascon_av_result_drain_if
    import ascon_pkg::*;
#(
    parameter int unsigned WORD_W = ASCON_WORD_W
) ();

    logic [WORD_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/ascon_av_result_drain.sv
// Waits for the ASCON core outputs to settle, snapshots ct||tag and pt, flags
// authentication failure and drains the snapshot as 20 MSW-first 32-bit beats.
module ascon_av_result_drain
    import ascon_pkg::*;
#(
    parameter int unsigned CT_W          = ASCON_CT_W,
    parameter int unsigned PT_W          = ASCON_PT_W,
    parameter int unsigned WORD_W        = ASCON_WORD_W,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CT_W-1:0]         ct_in,
    input  logic [PT_W-1:0]         pt_in,
    ascon_av_result_drain_if.master m_axis,
    output logic                    busy,
    output logic                    auth_fail,
    output logic                    done
);

    localparam int unsigned SNAP_W = CT_W + PT_W;
    localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BeatLast   = CNT_W'(TOTAL_BEATS - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    beat_q, beat_d;
    logic [SNAP_W-1:0]   snap_q, snap_d;
    logic [WORD_W-1:0]   tdata_q, tdata_d;
    logic                tvalid_q, tvalid_d;
    logic                tlast_q, tlast_d;
    logic                auth_fail_q, auth_fail_d;
    logic                hs;

    // Beat idx of a snapshot, counted from the most significant word.
    function automatic logic [WORD_W-1:0] beat_word(input logic [SNAP_W-1:0] snap,
                                                    input int unsigned idx);
        logic [SNAP_W-1:0] shifted;
        shifted = snap << (idx * WORD_W);
        return shifted[SNAP_W-1 -: WORD_W];
    endfunction

    assign hs = tvalid_q && m_axis.tready;

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        beat_d      = beat_q;
        snap_d      = snap_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        auth_fail_d = auth_fail_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StSettle;
                    cnt_d       = '0;
                    auth_fail_d = 1'b0;
                end
            end
            StSettle: begin
                cnt_d = cnt_q + 1'b1;
                if (start) begin
                    // A fresh request restarts the settle window.
                    cnt_d = '0;
                end else if (cnt_q == SettleLast) begin
                    snap_d      = {ct_in, pt_in};
                    auth_fail_d = (pt_in == ASCON_FAIL_PT);
                    beat_d      = '0;
                    tdata_d     = ct_in[CT_W-1 -: WORD_W];
                    tvalid_d    = 1'b1;
                    tlast_d     = (BeatLast == '0);
                    state_d     = StStream;
                end
            end
            StStream: begin
                if (hs) begin
                    if (beat_q == BeatLast) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        state_d  = StDone;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        tdata_d = beat_word(snap_q, 32'(beat_q) + 32'd1);
                        tlast_d = ((beat_q + 1'b1) == BeatLast);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            beat_q      <= '0;
            snap_q      <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            auth_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            beat_q      <= beat_d;
            snap_q      <= snap_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            auth_fail_q <= auth_fail_d;
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign busy          = (state_q == StSettle) || (state_q == StStream);
    assign done          = (state_q == StDone);
    assign auth_fail     = auth_fail_q;

endmodule

// File: tb/tb_ascon_av_result_drain.sv
// Scoreboard bench for the ASCON result drain: stimulus pushes expected beats,
// a negedge monitor pops and compares on every handshake.
module tb_ascon_av_result_drain;
    import ascon_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [383:0] ct;
    logic [255:0] pt;
    logic         busy;
    logic         auth_fail;
    logic         done;

    always #5 clk = ~clk;

    ascon_av_result_drain_if m_if ();

    ascon_av_result_drain dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ct_in     (ct),
        .pt_in     (pt),
        .m_axis    (m_if),
        .busy      (busy),
        .auth_fail (auth_fail),
        .done      (done)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [32:0] exp_q[$];
    int          hs_count   = 0;
    int          done_count = 0;
    logic        stalled    = 1'b0;
    logic [31:0] stall_data;
    logic        stall_last;
    logic        bp_mode    = 1'b0;
    logic [3:0]  bp_pat     = 4'b1001;
    int          cyc        = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [383:0] c, input logic [255:0] p);
        logic [639:0] s;
        s = {c, p};
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back({(i == 19), s[639 - 32*i -: 32]});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_mode) m_if.tready = bp_pat[cyc % 4];
        cyc++;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_tvalid(output int n);
        n = 0;
        while (!m_if.tvalid && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 300) begin
            tick();
            n++;
        end
        check("done_seen", 64'(done), 64'd1);
    endtask

    // Monitor: compares every handshake against the scoreboard and checks stall stability.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (done) done_count++;
            if (m_if.tvalid) begin
                if (stalled) begin
                    check("stall_tdata", 64'(m_if.tdata), 64'(stall_data));
                    check("stall_tlast", 64'(m_if.tlast), 64'(stall_last));
                end
                if (m_if.tready) begin
                    hs_count++;
                    stalled = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_beat: got %0h, expected no beat", m_if.tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_tdata", 64'(m_if.tdata), 64'(e[31:0]));
                        check("beat_tlast", 64'(m_if.tlast), 64'(e[32]));
                    end
                end else begin
                    stalled    = 1'b1;
                    stall_data = m_if.tdata;
                    stall_last = m_if.tlast;
                end
            end else begin
                if (stalled) check("tvalid_drop", 64'd0, 64'd1);
                stalled = 1'b0;
            end
        end
    end

    initial begin
        logic [383:0] ramp;
        logic [383:0] ct_b;
        logic [255:0] pt_a;
        int           n;
        int           dc;
        logic         seen;

        rst         = 1'b1;
        start       = 1'b0;
        ct          = '0;
        pt          = '0;
        m_if.tready = 1'b1;
        ramp        = '0;
        for (int i = 1; i <= 48; i++) ramp = {ramp[375:0], 8'(i)};
        pt_a = {32{8'h11}};

        // Reset state
        repeat (3) tick();
        check("rst_tvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_tdata", 64'(m_if.tdata), 64'd0);
        check("rst_tlast", 64'(m_if.tlast), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_auth_fail", 64'(auth_fail), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        tick();

        // 1. Nominal transfer
        ct = ramp;
        pt = pt_a;
        push_exp(ramp, pt_a);
        hs_count = 0;
        start_pulse();
        check("t1_busy", 64'(busy), 64'd1);
        wait_tvalid(n);
        check("t1_settle_latency", 64'(n), 64'd64);
        wait_done(n);
        check("t1_drain_cycles", 64'(n), 64'd20);
        check("t1_busy_in_done", 64'(busy), 64'd0);
        check("t1_auth_fail", 64'(auth_fail), 64'd0);
        tick();
        check("t1_done_width", 64'(done), 64'd0);
        check("t1_hs_count", 64'(hs_count), 64'd20);
        check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

        // 2. Authentication failure
        ct = ~ramp;
        pt = '1;
        push_exp(~ramp, '1);
        hs_count = 0;
        start_pulse();
        wait_tvalid(n);
        check("t2_settle_latency", 64'(n), 64'd64);
        check("t2_auth_fail_snap", 64'(auth_fail), 64'd1);
        wait_done(n);
        tick();
        check("t2_auth_fail_hold", 64'(auth_fail), 64'd1);
        check("t2_hs_count", 64'(hs_count), 64'd20);

        // 3. Backpressure 1,0,0,1
        ct = {ramp[191:0], ramp[383:192]};
        pt = pt_a ^ {8{32'hA5A5_0F0F}};
        push_exp({ramp[191:0], ramp[383:192]}, pt_a ^ {8{32'hA5A5_0F0F}});
        hs_count = 0;
        bp_mode  = 1'b1;
        start_pulse();
        check("t3_auth_fail_clear", 64'(auth_fail), 64'd0);
        wait_tvalid(n);
        check("t3_settle_latency", 64'(n), 64'd64);
        wait_done(n);
        bp_mode     = 1'b0;
        m_if.tready = 1'b1;
        tick();
        check("t3_hs_count", 64'(hs_count), 64'd20);
        check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

        // 4. Restart in SETTLE, ct_in changed before the snapshot
        ct       = ramp;
        pt       = pt_a;
        hs_count = 0;
        start_pulse();
        repeat (9) tick();
        start_pulse();
        repeat (19) tick();
        ct_b = ramp ^ {12{32'hDEAD_BEEF}};
        ct   = ct_b;
        push_exp(ct_b, pt_a);
        n = 19;
        while (!m_if.tvalid && n < 200) begin
            tick();
            n++;
        end
        check("t4_restart_latency", 64'(n), 64'd64);
        wait_done(n);
        tick();
        check("t4_hs_count", 64'(hs_count), 64'd20);

        // 5. Snapshot isolation and ignored start during STREAM
        ct = ramp;
        pt = ~pt_a;
        push_exp(ramp, ~pt_a);
        hs_count = 0;
        start_pulse();
        wait_tvalid(n);
        repeat (3) tick();
        ct = '0;
        pt = '1;
        start_pulse();
        wait_done(n);
        tick();
        check("t5_hs_count", 64'(hs_count), 64'd20);
        check("t5_busy_after", 64'(busy), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (m_if.tvalid || busy) seen = 1'b1;
        end
        check("t5_no_second_xfer", 64'(seen), 64'd0);
        check("t5_queue_empty", 64'(exp_q.size()), 64'd0);

        // 6. Reset mid-stream at beat 7
        ct = ramp;
        pt = pt_a;
        push_exp(ramp, pt_a);
        hs_count = 0;
        start_pulse();
        wait_tvalid(n);
        n = 0;
        while (hs_count < 7 && n < 100) begin
            tick();
            n++;
        end
        check("t6_reached_beat7", 64'(hs_count), 64'd7);
        rst = 1'b1;
        tick();
        exp_q.delete();
        rst = 1'b0;
        dc  = done_count;
        check("t6_tvalid", 64'(m_if.tvalid), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_tdata", 64'(m_if.tdata), 64'd0);
        repeat (80) tick();
        check("t6_no_done", 64'(done_count), 64'(dc));
        ct = ~ramp;
        pt = pt_a;
        push_exp(~ramp, pt_a);
        hs_count = 0;
        start_pulse();
        wait_tvalid(n);
        check("t6_settle_latency", 64'(n), 64'd64);
        wait_done(n);
        check("t6_drain_cycles", 64'(n), 64'd20);
        tick();
        check("t6_hs_count", 64'(hs_count), 64'd20);
        check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
